// File: rtl/regfile_mp.sv
// Multi-port register file with registered write-first reads, optional hardwired zero register,
// and a per-register busy scoreboard for tracking in-flight producers.
module regfile_mp #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned READ_PORTS  = 2,
    parameter int unsigned WRITE_PORTS = 1,
    parameter int unsigned ZERO_REG    = 1
) (
    input  logic                              i_clock,
    input  logic                              i_reset,      // asynchronous, active-low
    input  logic [READ_PORTS*ADDR_WIDTH-1:0]  i_rd_addr,
    output logic [READ_PORTS*DATA_WIDTH-1:0]  o_rd_data,
    output logic [READ_PORTS-1:0]             o_rd_busy,
    input  logic [WRITE_PORTS-1:0]            i_wr_en,
    input  logic [WRITE_PORTS*ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [WRITE_PORTS*DATA_WIDTH-1:0] i_wr_data,
    input  logic                              i_claim_en,
    input  logic [ADDR_WIDTH-1:0]             i_claim_addr
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]           r_mem [DEPTH];
    logic [DEPTH-1:0]                r_busy;
    logic [READ_PORTS*DATA_WIDTH-1:0] r_rd_data;
    logic [READ_PORTS-1:0]           r_rd_busy;

    logic [DATA_WIDTH-1:0]           w_mem_nxt [DEPTH];
    logic [DEPTH-1:0]                w_busy_nxt;
    logic [READ_PORTS*DATA_WIDTH-1:0] w_rd_data;
    logic [READ_PORTS-1:0]           w_rd_busy;

    function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // Writes applied in ascending port order so the highest-indexed colliding port wins;
    // the claim is applied last so a new producer overrides a same-cycle retiring write.
    always_comb begin
        w_mem_nxt  = r_mem;
        w_busy_nxt = r_busy;
        for (int p = 0; p < int'(WRITE_PORTS); p++) begin
            if (i_wr_en[p] && !is_zero(i_wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH])) begin
                w_mem_nxt[i_wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH]]  = i_wr_data[p*DATA_WIDTH +: DATA_WIDTH];
                w_busy_nxt[i_wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
            end
        end
        if (i_claim_en && !is_zero(i_claim_addr)) begin
            w_busy_nxt[i_claim_addr] = 1'b1;
        end
    end

    // Reads see post-edge state, which gives the write-first bypass for free.
    always_comb begin
        w_rd_data = '0;
        w_rd_busy = '0;
        for (int k = 0; k < int'(READ_PORTS); k++) begin
            if (!is_zero(i_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
                w_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = w_mem_nxt[i_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]];
                w_rd_busy[k] = w_busy_nxt[i_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]];
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_busy    <= '0;
            r_rd_data <= '0;
            r_rd_busy <= '0;
        end else begin
            r_mem     <= w_mem_nxt;
            r_busy    <= w_busy_nxt;
            r_rd_data <= w_rd_data;
            r_rd_busy <= w_rd_busy;
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_rd_busy = r_rd_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: three instances cover the default-style build with two write
// ports, a build without the zero register, and a narrow four-read-port build.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: DW32 AW5 RP2 WP2 ZERO_REG=1
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic [1:0]  a_wr_en;
    logic [9:0]  a_wr_addr;
    logic [63:0] a_wr_data;
    logic        a_claim_en;
    logic [4:0]  a_claim_addr;

    // Instance B: DW32 AW5 RP2 WP1 ZERO_REG=0
    logic [9:0]  b_rd_addr;
    logic [63:0] b_rd_data;
    logic [1:0]  b_rd_busy;
    logic [0:0]  b_wr_en;
    logic [4:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic        b_claim_en;
    logic [4:0]  b_claim_addr;

    // Instance C: DW16 AW3 RP4 WP1 ZERO_REG=1
    logic [11:0] c_rd_addr;
    logic [63:0] c_rd_data;
    logic [3:0]  c_rd_busy;
    logic [0:0]  c_wr_en;
    logic [2:0]  c_wr_addr;
    logic [15:0] c_wr_data;
    logic        c_claim_en;
    logic [2:0]  c_claim_addr;

    regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_PORTS(2), .WRITE_PORTS(2), .ZERO_REG(1))
    u_dut_a (
        .i_clock(clk), .i_reset(rst_n),
        .i_rd_addr(a_rd_addr), .o_rd_data(a_rd_data), .o_rd_busy(a_rd_busy),
        .i_wr_en(a_wr_en), .i_wr_addr(a_wr_addr), .i_wr_data(a_wr_data),
        .i_claim_en(a_claim_en), .i_claim_addr(a_claim_addr)
    );

    regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_PORTS(2), .WRITE_PORTS(1), .ZERO_REG(0))
    u_dut_b (
        .i_clock(clk), .i_reset(rst_n),
        .i_rd_addr(b_rd_addr), .o_rd_data(b_rd_data), .o_rd_busy(b_rd_busy),
        .i_wr_en(b_wr_en), .i_wr_addr(b_wr_addr), .i_wr_data(b_wr_data),
        .i_claim_en(b_claim_en), .i_claim_addr(b_claim_addr)
    );

    regfile_mp #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .READ_PORTS(4), .WRITE_PORTS(1), .ZERO_REG(1))
    u_dut_c (
        .i_clock(clk), .i_reset(rst_n),
        .i_rd_addr(c_rd_addr), .o_rd_data(c_rd_data), .o_rd_busy(c_rd_busy),
        .i_wr_en(c_wr_en), .i_wr_addr(c_wr_addr), .i_wr_data(c_wr_data),
        .i_claim_en(c_claim_en), .i_claim_addr(c_claim_addr)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_rd_addr = '0; a_wr_en = '0; a_wr_addr = '0; a_wr_data = '0;
        a_claim_en = 1'b0; a_claim_addr = '0;
        b_rd_addr = '0; b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0;
        b_claim_en = 1'b0; b_claim_addr = '0;
        c_rd_addr = '0; c_wr_en = '0; c_wr_addr = '0; c_wr_data = '0;
        c_claim_en = 1'b0; c_claim_addr = '0;
        step();
        step();
        check("reset_a_data", a_rd_data, 64'h0);
        check("reset_b_data", b_rd_data, 64'h0);
        check("reset_c_busy", {60'h0, c_rd_busy}, 64'h0);
        rst_n = 1'b1;

        // Write r5 plus same-cycle claim, then async reset mid-cycle
        a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd5}; a_wr_data = {32'h0, 32'hDEADBEEF};
        a_claim_en = 1'b1; a_claim_addr = 5'd5; a_rd_addr = {5'd0, 5'd5};
        step();
        check("r5_write_bypass", {32'h0, a_rd_data[31:0]}, 64'hDEADBEEF);
        check("r5_claim_busy", {63'h0, a_rd_busy[0]}, 64'h1);
        a_wr_en = 2'b00; a_claim_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_data", a_rd_data, 64'h0);
        check("async_reset_busy", {62'h0, a_rd_busy}, 64'h0);
        step();
        rst_n = 1'b1;
        step();
        check("r5_after_reset", {32'h0, a_rd_data[31:0]}, 64'h0);
        check("r5_busy_after_reset", {63'h0, a_rd_busy[0]}, 64'h0);

        // Basic write/read and same-cycle bypass on port 1
        a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd7}; a_wr_data = {32'h0, 32'h12345678};
        a_rd_addr = {5'd7, 5'd5};
        step();
        check("r7_bypass_p1", {32'h0, a_rd_data[63:32]}, 64'h12345678);
        check("r5_p0_zero", {32'h0, a_rd_data[31:0]}, 64'h0);
        a_wr_en = 2'b00; a_rd_addr = {5'd5, 5'd7};
        step();
        check("r7_read_p0", {32'h0, a_rd_data[31:0]}, 64'h12345678);
        check("r5_p1_zero", {32'h0, a_rd_data[63:32]}, 64'h0);

        // Zero register on A, ordinary r0 on B
        a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd0}; a_wr_data = {32'h0, 32'hFFFFFFFF};
        a_claim_en = 1'b1; a_claim_addr = 5'd0; a_rd_addr = {5'd0, 5'd0};
        b_wr_en = 1'b1; b_wr_addr = 5'd0; b_wr_data = 32'hFFFFFFFF;
        b_claim_en = 1'b1; b_claim_addr = 5'd0; b_rd_addr = {5'd0, 5'd0};
        step();
        check("zr_a_data_bypass", a_rd_data, 64'h0);
        check("zr_a_busy_bypass", {62'h0, a_rd_busy}, 64'h0);
        check("nozr_b_data_bypass", {32'h0, b_rd_data[31:0]}, 64'hFFFFFFFF);
        check("nozr_b_busy_bypass", {63'h0, b_rd_busy[0]}, 64'h1);
        a_wr_en = 2'b00; a_claim_en = 1'b0; b_wr_en = 1'b0; b_claim_en = 1'b0;
        step();
        check("zr_a_data", a_rd_data, 64'h0);
        check("nozr_b_data_p1", {32'h0, b_rd_data[63:32]}, 64'hFFFFFFFF);
        check("nozr_b_busy_p1", {63'h0, b_rd_busy[1]}, 64'h1);

        // Write collisions: higher port wins, both orders
        a_wr_en = 2'b11; a_wr_addr = {5'd3, 5'd3}; a_wr_data = {32'h0000BBBB, 32'hAAAA0000};
        a_rd_addr = {5'd0, 5'd3};
        step();
        check("coll_r3_bypass", {32'h0, a_rd_data[31:0]}, 64'h0000BBBB);
        a_wr_addr = {5'd4, 5'd4}; a_wr_data = {32'hAAAA0000, 32'h0000BBBB};
        a_rd_addr = {5'd3, 5'd4};
        step();
        check("coll_r4_bypass", {32'h0, a_rd_data[31:0]}, 64'hAAAA0000);
        check("coll_r3_stored", {32'h0, a_rd_data[63:32]}, 64'h0000BBBB);
        a_wr_en = 2'b00;

        // Scoreboard
        a_claim_en = 1'b1; a_claim_addr = 5'd9; a_rd_addr = {5'd3, 5'd9};
        step();
        check("sb_claim_r9", {62'h0, a_rd_busy}, 64'h1);
        a_claim_en = 1'b0;
        a_wr_en = 2'b10; a_wr_addr = {5'd9, 5'd0}; a_wr_data = {32'h9, 32'h0};
        step();
        check("sb_write_clears", {62'h0, a_rd_busy}, 64'h0);
        check("sb_write_data_p1", {32'h0, a_rd_data[31:0]}, 64'h9);
        a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd9}; a_wr_data = {32'h0, 32'h99};
        a_claim_en = 1'b1; a_claim_addr = 5'd9;
        step();
        check("sb_claim_and_write", {63'h0, a_rd_busy[0]}, 64'h1);
        check("sb_claim_write_data", {32'h0, a_rd_data[31:0]}, 64'h99);
        a_wr_en = 2'b00; a_claim_en = 1'b0;
        step();
        check("sb_busy_holds", {63'h0, a_rd_busy[0]}, 64'h1);
        a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd9}; a_wr_data = {32'h0, 32'h55};
        a_claim_en = 1'b1; a_claim_addr = 5'd10; a_rd_addr = {5'd10, 5'd9};
        step();
        check("sb_split_claim_write", {62'h0, a_rd_busy}, 64'h2);
        a_wr_en = 2'b00; a_claim_en = 1'b0;

        // Narrow four-read-port build
        for (int i = 0; i < 8; i++) begin
            c_wr_en = 1'b1; c_wr_addr = 3'(i); c_wr_data = 16'(16'h1000 + i);
            step();
        end
        c_wr_en = 1'b0;
        c_rd_addr = {3'd4, 3'd3, 3'd2, 3'd1};
        step();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("sweep_r%0d", k + 1), {48'h0, c_rd_data[k*16 +: 16]},
                  64'(16'h1001 + k));
        end
        c_rd_addr = {3'd7, 3'd6, 3'd5, 3'd0};
        step();
        check("sweep_r0_zero", {48'h0, c_rd_data[15:0]}, 64'h0);
        check("sweep_r5", {48'h0, c_rd_data[31:16]}, 64'h1005);
        check("sweep_r6", {48'h0, c_rd_data[47:32]}, 64'h1006);
        check("sweep_r7", {48'h0, c_rd_data[63:48]}, 64'h1007);
        check("sweep_busy", {60'h0, c_rd_busy}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
